mem_port_arbiter: RTL and testbench

Non-preemptive two-port arbiter and sequencer that shares one unified, fixed-latency memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. It replaces the separate instruction and main memories with a single memory behind this block. It holds each granted command stable on the memory bus for `LAT` cycles, captures the read data, and returns a one-cycle ready pulse to the owner. It also produces per-port stall signals that feed the hazard unit's PC/IF-ID write enables and the pipeline `enable`.

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the pipeline's fetch/data ports, the arbiter, and the unified memory.
// The slave modport is the arbiter's view; the master modport is the pipeline/memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        if_stall;
  logic        d_stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready,
    output mem_en, mem_we, mem_funct3, mem_addr, mem_wdata, if_stall, d_stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  mem_en, mem_we, mem_funct3, mem_addr, mem_wdata, if_stall, d_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Non-preemptive fetch/data arbiter in front of a single fixed-latency memory.
// Data port wins ties; the port just served is masked during its ready cycle.
module mem_port_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(LAT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_owner_d;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic        w_grant;
  logic        w_grant_d;
  logic        w_capture;
  logic        w_mask_d;
  logic        w_mask_if;
  logic        w_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_grant_d   = 1'b0;
    w_capture   = 1'b0;
    w_mask_d    = (r_state == S_DONE) &&  r_owner_d;
    w_mask_if   = (r_state == S_DONE) && !r_owner_d;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.d_req && !w_mask_d) begin
          w_grant   = 1'b1;
          w_grant_d = 1'b1;
        end else if (bus.if_req && !w_mask_if) begin
          w_grant   = 1'b1;
        end
        w_state_nxt = w_grant ? S_BUSY : S_IDLE;
        w_cnt_nxt   = '0;
      end
      S_BUSY: begin
        if (r_cnt == LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Command is latched only at grant, so requester changes while BUSY are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_d  <= 1'b0;
      r_addr     <= '0;
      r_funct3   <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_grant) begin
        r_owner_d <= w_grant_d;
        r_addr    <= w_grant_d ? bus.d_addr   : bus.if_addr;
        r_funct3  <= w_grant_d ? bus.d_funct3 : 3'b010;
        r_we      <= w_grant_d & bus.d_we;
        r_wdata   <= w_grant_d ? bus.d_wdata  : '0;
      end
      if (w_capture) begin
        if (r_owner_d) begin
          r_d_rdata  <= r_we ? '0 : bus.mem_rdata;
        end else begin
          r_if_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign w_busy         = (r_state == S_BUSY);
  assign bus.mem_en     = w_busy;
  assign bus.mem_we     = w_busy && (r_cnt == '0) && r_we;
  assign bus.mem_addr   = w_busy ? r_addr   : '0;
  assign bus.mem_funct3 = w_busy ? r_funct3 : '0;
  assign bus.mem_wdata  = w_busy ? r_wdata  : '0;

  assign bus.if_ready   = (r_state == S_DONE) && !r_owner_d;
  assign bus.d_ready    = (r_state == S_DONE) &&  r_owner_d;
  assign bus.if_rdata   = r_if_rdata;
  assign bus.d_rdata    = r_d_rdata;

  assign bus.if_stall   = bus.if_req & ~bus.if_ready;
  assign bus.d_stall    = bus.d_req  & ~bus.d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on LAT=2 and LAT=1 instances plus a
// randomized run against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  localparam int LAT0 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if b0 ();
  mem_port_arbiter_if b1 ();

  mem_port_arbiter #(.LAT(LAT0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  mem_port_arbiter #(.LAT(1))    dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  assign b0.mem_rdata = mem[b0.mem_addr[9:2]];
  assign b1.mem_rdata = mem[b1.mem_addr[9:2]];

  int checks   = 0;
  int failures = 0;

  // Memory writes are applied mid-cycle, where mem_we is stable.
  task automatic tick();
    @(negedge clk);
    if (b0.mem_we === 1'b1) mem[b0.mem_addr[9:2]] = b0.mem_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b0.if_req = 1'b0; b0.if_addr = '0; b0.d_req = 1'b0; b0.d_we = 1'b0;
    b0.d_funct3 = '0; b0.d_addr = '0; b0.d_wdata = '0;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0;
    b1.d_funct3 = '0; b1.d_addr = '0; b1.d_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [136:0] v0;
    logic [136:0] v1;
    idle_inputs();
    rst = 1'b1;
    tick();
    v0 = {b0.mem_en, b0.mem_we, b0.mem_funct3, b0.mem_addr, b0.mem_wdata,
          b0.if_ready, b0.d_ready, b0.if_rdata, b0.d_rdata};
    v1 = {b1.mem_en, b1.mem_we, b1.mem_funct3, b1.mem_addr, b1.mem_wdata,
          b1.if_ready, b1.d_ready, b1.if_rdata, b1.d_rdata};
    checks++; if (v0 !== '0) begin failures++; $display("FAIL reset_outs_lat2 got=%h exp=0", v0); end
    checks++; if (v1 !== '0) begin failures++; $display("FAIL reset_outs_lat1 got=%h exp=0", v1); end
    checks++; if ({b0.if_stall, b0.d_stall} !== 2'b00) begin failures++; $display("FAIL reset_stall got=%b exp=00", {b0.if_stall, b0.d_stall}); end
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    logic e_en, e_rdy, e_st;
    do_reset();
    mem[4] = 32'h0050_0093;
    tick();
    b0.if_req = 1'b1; b0.if_addr = 32'h10;
    #1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin tick(); if (c == 4) b0.if_req = 1'b0; #1; end
      e_en = (c == 1) || (c == 2); e_rdy = (c == 3); e_st = (c <= 2);
      checks++; if (b0.mem_en !== e_en) begin failures++; $display("FAIL fetch_en c=%0d got=%b exp=%b", c, b0.mem_en, e_en); end
      checks++; if (b0.if_ready !== e_rdy) begin failures++; $display("FAIL fetch_rdy c=%0d got=%b exp=%b", c, b0.if_ready, e_rdy); end
      checks++; if (b0.d_ready !== 1'b0) begin failures++; $display("FAIL fetch_drdy c=%0d got=%b exp=0", c, b0.d_ready); end
      checks++; if (b0.if_stall !== e_st) begin failures++; $display("FAIL fetch_stall c=%0d got=%b exp=%b", c, b0.if_stall, e_st); end
      if (e_en) begin
        checks++; if ({b0.mem_addr, b0.mem_funct3, b0.mem_we} !== {32'h10, 3'b010, 1'b0}) begin failures++; $display("FAIL fetch_cmd c=%0d got=%h/%b/%b exp=10/010/0", c, b0.mem_addr, b0.mem_funct3, b0.mem_we); end
      end
      if (e_rdy) begin
        checks++; if (b0.if_rdata !== 32'h0050_0093) begin failures++; $display("FAIL fetch_rdata got=%h exp=00500093", b0.if_rdata); end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] va, vb, e_addr;
    logic [2:0]  e_f3;
    logic        e_en, e_drdy, e_irdy, e_ds, e_is;
    do_reset();
    va = $urandom; vb = $urandom;
    mem[128] = va; mem[5] = vb;
    tick();
    b0.d_req = 1'b1; b0.d_we = 1'b0; b0.d_addr = 32'h200; b0.d_funct3 = 3'b100;
    b0.if_req = 1'b1; b0.if_addr = 32'h14;
    #1;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) begin tick(); if (c == 4) b0.d_req = 1'b0; if (c == 7) b0.if_req = 1'b0; #1; end
      e_en = (c == 1) || (c == 2) || (c == 4) || (c == 5);
      e_addr = (c <= 2) ? 32'h200 : 32'h14;
      e_f3 = (c <= 2) ? 3'b100 : 3'b010;
      e_drdy = (c == 3); e_irdy = (c == 6);
      e_ds = (c <= 2); e_is = (c <= 5);
      checks++; if (b0.mem_en !== e_en) begin failures++; $display("FAIL simul_en c=%0d got=%b exp=%b", c, b0.mem_en, e_en); end
      if (e_en) begin
        checks++; if ({b0.mem_addr, b0.mem_funct3} !== {e_addr, e_f3}) begin failures++; $display("FAIL simul_cmd c=%0d got=%h/%b exp=%h/%b", c, b0.mem_addr, b0.mem_funct3, e_addr, e_f3); end
      end
      checks++; if ({b0.d_ready, b0.if_ready} !== {e_drdy, e_irdy}) begin failures++; $display("FAIL simul_rdy c=%0d got=%b%b exp=%b%b", c, b0.d_ready, b0.if_ready, e_drdy, e_irdy); end
      checks++; if ({b0.d_stall, b0.if_stall} !== {e_ds, e_is}) begin failures++; $display("FAIL simul_stall c=%0d got=%b%b exp=%b%b", c, b0.d_stall, b0.if_stall, e_ds, e_is); end
      if (e_drdy) begin
        checks++; if (b0.d_rdata !== va) begin failures++; $display("FAIL simul_drdata got=%h exp=%h", b0.d_rdata, va); end
      end
      if (e_irdy) begin
        checks++; if (b0.if_rdata !== vb) begin failures++; $display("FAIL simul_irdata got=%h exp=%h", b0.if_rdata, vb); end
      end
    end
  endtask

  task automatic test_store();
    logic e_we, e_rdy;
    do_reset();
    mem[64] = 32'h0;
    tick();
    b0.d_req = 1'b1; b0.d_we = 1'b1; b0.d_addr = 32'h100; b0.d_wdata = 32'hDEAD_BEEF; b0.d_funct3 = 3'b010;
    #1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin tick(); if (c == 4) begin b0.d_req = 1'b0; b0.d_we = 1'b0; end #1; end
      e_we = (c == 1); e_rdy = (c == 3);
      checks++; if (b0.mem_we !== e_we) begin failures++; $display("FAIL store_we c=%0d got=%b exp=%b", c, b0.mem_we, e_we); end
      checks++; if (b0.d_ready !== e_rdy) begin failures++; $display("FAIL store_rdy c=%0d got=%b exp=%b", c, b0.d_ready, e_rdy); end
      if (c == 1 || c == 2) begin
        checks++; if ({b0.mem_addr, b0.mem_wdata} !== {32'h100, 32'hDEAD_BEEF}) begin failures++; $display("FAIL store_cmd c=%0d got=%h/%h exp=100/deadbeef", c, b0.mem_addr, b0.mem_wdata); end
      end
      if (e_rdy) begin
        checks++; if (b0.d_rdata !== 32'h0) begin failures++; $display("FAIL store_rdata got=%h exp=0", b0.d_rdata); end
      end
    end
    checks++; if (mem[64] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_mem got=%h exp=deadbeef", mem[64]); end
  endtask

  task automatic test_held();
    logic [31:0] vc, vd, e_addr;
    logic        e_en, e_rdy;
    do_reset();
    vc = $urandom; vd = $urandom;
    mem[32] = vc; mem[33] = vd;
    tick();
    b0.d_req = 1'b1; b0.d_we = 1'b0; b0.d_addr = 32'h80; b0.d_funct3 = 3'b010;
    #1;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin tick(); if (c == 4) b0.d_addr = 32'h84; if (c == 5) b0.d_req = 1'b0; #1; end
      e_en = (c == 1) || (c == 2) || (c == 5) || (c == 6);
      e_rdy = (c == 3) || (c == 7);
      e_addr = (c <= 2) ? 32'h80 : 32'h84;
      checks++; if (b0.mem_en !== e_en) begin failures++; $display("FAIL held_en c=%0d got=%b exp=%b", c, b0.mem_en, e_en); end
      checks++; if (b0.d_ready !== e_rdy) begin failures++; $display("FAIL held_rdy c=%0d got=%b exp=%b", c, b0.d_ready, e_rdy); end
      if (e_en) begin
        checks++; if (b0.mem_addr !== e_addr) begin failures++; $display("FAIL held_addr c=%0d got=%h exp=%h", c, b0.mem_addr, e_addr); end
      end
      if (e_rdy) begin
        checks++; if (b0.d_rdata !== ((c == 3) ? vc : vd)) begin failures++; $display("FAIL held_rdata c=%0d got=%h exp=%h", c, b0.d_rdata, (c == 3) ? vc : vd); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ve;
    logic        e_en, e_rdy;
    do_reset();
    ve = $urandom; mem[6] = ve;
    tick();
    b0.if_req = 1'b1; b0.if_addr = 32'h18;
    tick();
    tick();
    #1;
    checks++; if (b0.mem_en !== 1'b1) begin failures++; $display("FAIL rstmid_pre_en got=%b exp=1", b0.mem_en); end
    rst = 1'b1;
    #1;
    checks++; if ({b0.mem_en, b0.mem_addr, b0.if_ready} !== '0) begin failures++; $display("FAIL rstmid_abort got=%b/%h/%b exp=0/0/0", b0.mem_en, b0.mem_addr, b0.if_ready); end
    for (int c = 3; c <= 7; c++) begin
      tick();
      if (c == 3) rst = 1'b0;
      if (c == 7) b0.if_req = 1'b0;
      #1;
      e_en = (c == 4) || (c == 5); e_rdy = (c == 6);
      checks++; if (b0.mem_en !== e_en) begin failures++; $display("FAIL rstmid_en c=%0d got=%b exp=%b", c, b0.mem_en, e_en); end
      checks++; if (b0.if_ready !== e_rdy) begin failures++; $display("FAIL rstmid_rdy c=%0d got=%b exp=%b", c, b0.if_ready, e_rdy); end
      if (e_rdy) begin
        checks++; if (b0.if_rdata !== ve) begin failures++; $display("FAIL rstmid_rdata got=%h exp=%h", b0.if_rdata, ve); end
      end
    end
  endtask

  task automatic test_lat1_sweep();
    logic [31:0] ed, ei;
    logic        e_en, e_drdy, e_irdy;
    ed = '0; ei = '0;
    do_reset();
    tick();
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_funct3 = 3'b010; b1.d_addr = $urandom & 32'hFFFF_FFFC;
    b1.if_req = 1'b1; b1.if_addr = $urandom & 32'hFFFF_FFFC;
    #1;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin
        tick();
        if (c % 4 == 3) b1.d_addr = $urandom & 32'hFFFF_FFFC;
        if (c % 4 == 1 && c >= 5) b1.if_addr = $urandom & 32'hFFFF_FFFC;
        #1;
      end
      if (c % 4 == 0) ed = mem[b1.d_addr[9:2]];
      if (c % 4 == 2) ei = mem[b1.if_addr[9:2]];
      e_en = (c % 2 == 1);
      e_drdy = (c % 4 == 2);
      e_irdy = (c % 4 == 0) && (c > 0);
      checks++; if (b1.mem_en !== e_en) begin failures++; $display("FAIL lat1_en c=%0d got=%b exp=%b", c, b1.mem_en, e_en); end
      checks++; if ({b1.d_ready, b1.if_ready} !== {e_drdy, e_irdy}) begin failures++; $display("FAIL lat1_rdy c=%0d got=%b%b exp=%b%b", c, b1.d_ready, b1.if_ready, e_drdy, e_irdy); end
      if (e_drdy) begin
        checks++; if (b1.d_rdata !== ed) begin failures++; $display("FAIL lat1_drdata c=%0d got=%h exp=%h", c, b1.d_rdata, ed); end
      end
      if (e_irdy) begin
        checks++; if (b1.if_rdata !== ei) begin failures++; $display("FAIL lat1_irdata c=%0d got=%h exp=%h", c, b1.if_rdata, ei); end
      end
    end
    do_reset();
    tick();
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h40; b1.d_wdata = 32'h1234_5678; b1.d_funct3 = 3'b010;
    tick();
    #1;
    checks++; if ({b1.mem_en, b1.mem_we, b1.mem_wdata} !== {2'b11, 32'h1234_5678}) begin failures++; $display("FAIL lat1_store_we got=%b%b/%h exp=11/12345678", b1.mem_en, b1.mem_we, b1.mem_wdata); end
    tick();
    b1.d_req = 1'b0;
    #1;
    checks++; if ({b1.d_ready, b1.mem_we, b1.d_rdata} !== {2'b10, 32'h0}) begin failures++; $display("FAIL lat1_store_rdy got=%b%b/%h exp=10/0", b1.d_ready, b1.mem_we, b1.d_rdata); end
  endtask

  // Model: the arbiter is free at m_free; a grant at cycle t occupies t+1..t+LAT and
  // readies at t+LAT+1, where the served port is excluded from that cycle's arbitration.
  task automatic test_random(input int n);
    int m_free, m_done, m_last, b_lo, b_hi, r_cyc, r_port, mask, gport;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [2:0]  e_f3;
    logic        e_we, e_irdy, e_drdy, busy, rp_if, rp_d;
    m_free = 0; m_done = -1; m_last = -1; b_lo = -1; b_hi = -2; r_cyc = -1; r_port = -1;
    e_addr = '0; e_wdata = '0; e_data = '0; e_f3 = '0; e_we = 1'b0; rp_if = 1'b0; rp_d = 1'b0;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    for (int c = 0; c < n; c++) begin
      tick();
      if (rp_if ? ($urandom_range(0, 1) == 1) : (!b0.if_req && $urandom_range(0, 2) == 0)) begin
        b0.if_req = 1'b1; b0.if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (rp_if) begin
        b0.if_req = 1'b0;
      end
      if (rp_d ? ($urandom_range(0, 1) == 1) : (!b0.d_req && $urandom_range(0, 2) == 0)) begin
        b0.d_req = 1'b1; b0.d_we = 1'($urandom); b0.d_funct3 = 3'($urandom);
        b0.d_addr = $urandom & 32'hFFFF_FFFC; b0.d_wdata = $urandom;
      end else if (rp_d) begin
        b0.d_req = 1'b0;
      end
      #1;
      e_irdy = (c == r_cyc) && (r_port == 0);
      e_drdy = (c == r_cyc) && (r_port == 1);
      busy = (c >= b_lo) && (c <= b_hi);
      checks++; if ({b0.if_ready, b0.d_ready} !== {e_irdy, e_drdy}) begin failures++; $display("FAIL rnd_rdy c=%0d got=%b%b exp=%b%b", c, b0.if_ready, b0.d_ready, e_irdy, e_drdy); end
      checks++; if (b0.mem_en !== busy) begin failures++; $display("FAIL rnd_en c=%0d got=%b exp=%b", c, b0.mem_en, busy); end
      checks++; if (b0.mem_we !== (busy && c == b_lo && e_we)) begin failures++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, b0.mem_we, busy && c == b_lo && e_we); end
      checks++; if ({b0.if_stall, b0.d_stall} !== {b0.if_req & ~e_irdy, b0.d_req & ~e_drdy}) begin failures++; $display("FAIL rnd_stall c=%0d got=%b%b exp=%b%b", c, b0.if_stall, b0.d_stall, b0.if_req & ~e_irdy, b0.d_req & ~e_drdy); end
      if (busy) begin
        checks++; if ({b0.mem_addr, b0.mem_funct3} !== {e_addr, e_f3}) begin failures++; $display("FAIL rnd_cmd c=%0d got=%h/%b exp=%h/%b", c, b0.mem_addr, b0.mem_funct3, e_addr, e_f3); end
        if (r_port == 1) begin
          checks++; if (b0.mem_wdata !== e_wdata) begin failures++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, b0.mem_wdata, e_wdata); end
        end
      end
      if (e_irdy) begin
        checks++; if (b0.if_rdata !== e_data) begin failures++; $display("FAIL rnd_irdata c=%0d got=%h exp=%h", c, b0.if_rdata, e_data); end
      end
      if (e_drdy) begin
        checks++; if (b0.d_rdata !== e_data) begin failures++; $display("FAIL rnd_drdata c=%0d got=%h exp=%h", c, b0.d_rdata, e_data); end
      end
      rp_if = e_irdy; rp_d = e_drdy;
      if (c >= m_free) begin
        mask = (c == m_done) ? m_last : -1;
        gport = -1;
        if (b0.d_req && mask != 1) gport = 1;
        else if (b0.if_req && mask != 0) gport = 0;
        if (gport >= 0) begin
          b_lo = c + 1; b_hi = c + LAT0; r_cyc = c + LAT0 + 1; r_port = gport;
          m_free = r_cyc; m_done = r_cyc; m_last = gport;
          if (gport == 1) begin
            e_addr = b0.d_addr; e_f3 = b0.d_funct3; e_we = b0.d_we; e_wdata = b0.d_wdata;
          end else begin
            e_addr = b0.if_addr; e_f3 = 3'b010; e_we = 1'b0; e_wdata = '0;
          end
          if (e_we) begin
            ref_mem[e_addr[9:2]] = e_wdata; e_data = '0;
          end else begin
            e_data = ref_mem[e_addr[9:2]];
          end
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store();
    test_held();
    test_reset_mid();
    test_lat1_sweep();
    test_random(600);
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
